// File: rtl/registro_pkg.sv
// Shared definitions for the universal register: operation-select encodings
// and the width of the select field. Imported by the design and its tester.
package registro_pkg;

  localparam int MODO_W = 3;

  localparam logic [MODO_W-1:0] MODO_SHL  = 3'b000;
  localparam logic [MODO_W-1:0] MODO_SHR  = 3'b001;
  localparam logic [MODO_W-1:0] MODO_ROL  = 3'b010;
  localparam logic [MODO_W-1:0] MODO_ROR  = 3'b011;
  localparam logic [MODO_W-1:0] MODO_LOAD = 3'b100;
  localparam logic [MODO_W-1:0] MODO_UP   = 3'b101;
  localparam logic [MODO_W-1:0] MODO_DOWN = 3'b110;
  localparam logic [MODO_W-1:0] MODO_CLR  = 3'b111;

endpackage

// File: rtl/registro_universal.sv
// WIDTH-bit universal register: shift, rotate, parallel load, up/down count
// and clear, with a registered ripple/carry flag for cascading instances.
module registro_universal
  import registro_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic              CLK,
  input  logic              RESET_L,
  input  logic              ENB,
  input  logic [MODO_W-1:0] MODO,
  input  logic [WIDTH-1:0]  D,
  input  logic              S_IN,
  output logic [WIDTH-1:0]  Q,
  output logic              RCO
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_next;
  logic             rco_next;

  // Select next register value and carry flag from the current Q; the flag
  // always reflects the pre-edge contents so cascades see a clean pulse.
  always_comb begin
    q_next   = Q;
    rco_next = 1'b0;
    if (ENB) begin
      case (MODO)
        MODO_SHL: begin
          q_next   = {Q[WIDTH-2:0], S_IN};
          rco_next = Q[WIDTH-1];
        end
        MODO_SHR: begin
          q_next   = {S_IN, Q[WIDTH-1:1]};
          rco_next = Q[0];
        end
        MODO_ROL: begin
          q_next   = {Q[WIDTH-2:0], Q[WIDTH-1]};
          rco_next = Q[WIDTH-1];
        end
        MODO_ROR: begin
          q_next   = {Q[0], Q[WIDTH-1:1]};
          rco_next = Q[0];
        end
        MODO_LOAD: begin
          q_next   = D;
          rco_next = 1'b0;
        end
        MODO_UP: begin
          // Carry leaves only through RCO; Q wraps modulo 2^WIDTH.
          q_next   = Q + ONE;
          rco_next = &Q;
        end
        MODO_DOWN: begin
          q_next   = Q - ONE;
          rco_next = ~|Q;
        end
        default: begin
          q_next   = '0;
          rco_next = 1'b0;
        end
      endcase
    end
  end

  // Register Q and RCO; reset clears both immediately regardless of CLK.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      Q   <= '0;
      RCO <= 1'b0;
    end else begin
      Q   <= q_next;
      RCO <= rco_next;
    end
  end

endmodule

// File: tb/tb_registro_universal.sv
// Scoreboard bench for registro_universal: a 4-bit instance, an 8-bit
// instance and a cascaded pair of 4-bit counters, all checked against an
// arithmetic reference model.
module tb_registro_universal;
  import registro_pkg::*;

  logic       clk;
  logic       rst_n;

  logic       enb4, s4;
  logic [2:0] m4;
  logic [3:0] d4;
  logic [3:0] q4;
  logic       rco4;

  logic       enb8, s8;
  logic [2:0] m8;
  logic [7:0] d8;
  logic [7:0] q8;
  logic       rco8;

  logic       enb_c;
  logic [3:0] q_lo, q_hi;
  logic       rco_lo, rco_hi;

  int checks = 0;
  int errors = 0;

  // expected {q, rco} per device, pushed by stimulus, popped by monitor
  int exp4_q[$], exp4_r[$], exp8_q[$], exp8_r[$];
  int explo_q[$], explo_r[$], exphi_q[$], exphi_r[$];

  // model state
  int mq4, mr4, mq8, mr8, mqlo, mrlo, mqhi, mrhi;

  registro_universal #(.WIDTH(4)) dut4 (
    .CLK(clk), .RESET_L(rst_n), .ENB(enb4), .MODO(m4), .D(d4), .S_IN(s4),
    .Q(q4), .RCO(rco4));

  registro_universal #(.WIDTH(8)) dut8 (
    .CLK(clk), .RESET_L(rst_n), .ENB(enb8), .MODO(m8), .D(d8), .S_IN(s8),
    .Q(q8), .RCO(rco8));

  registro_universal #(.WIDTH(4)) dut_lo (
    .CLK(clk), .RESET_L(rst_n), .ENB(enb_c), .MODO(MODO_UP), .D(4'd0),
    .S_IN(1'b0), .Q(q_lo), .RCO(rco_lo));

  registro_universal #(.WIDTH(4)) dut_hi (
    .CLK(clk), .RESET_L(rst_n), .ENB(rco_lo), .MODO(MODO_UP), .D(4'd0),
    .S_IN(1'b0), .Q(q_hi), .RCO(rco_hi));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference behaviour from the operation table, in plain integer arithmetic.
  function automatic void model(input int w, input int q, input int m,
                                input int enb, input int d, input int s,
                                output int nq, output int nr);
    int modv = 1 << w;
    int top  = q / (modv / 2);
    int bot  = q % 2;
    nq = q;
    nr = 0;
    if (enb != 0) begin
      case (m)
        0: begin nq = (q * 2 + s) % modv;            nr = top; end
        1: begin nq = s * (modv / 2) + q / 2;        nr = bot; end
        2: begin nq = (q * 2 + top) % modv;          nr = top; end
        3: begin nq = bot * (modv / 2) + q / 2;      nr = bot; end
        4: begin nq = d % modv;                      nr = 0;   end
        5: begin nq = (q + 1) % modv;                nr = (q == modv - 1) ? 1 : 0; end
        6: begin nq = (q + modv - 1) % modv;         nr = (q == 0) ? 1 : 0; end
        default: begin nq = 0;                       nr = 0;   end
      endcase
    end
  endfunction

  // Push expectations for the coming edge, advance the model, run one cycle.
  // Called at a falling edge with inputs already set.
  task automatic cycle();
    int nq, nr, hq, hr;
    if (!rst_n) begin
      mq4 = 0; mr4 = 0; mq8 = 0; mr8 = 0;
      mqlo = 0; mrlo = 0; mqhi = 0; mrhi = 0;
    end else begin
      model(4, mq4, int'(m4), int'(enb4), int'(d4), int'(s4), nq, nr);
      mq4 = nq; mr4 = nr;
      model(8, mq8, int'(m8), int'(enb8), int'(d8), int'(s8), nq, nr);
      mq8 = nq; mr8 = nr;
      model(4, mqhi, 5, mrlo, 0, 0, hq, hr);
      model(4, mqlo, 5, int'(enb_c), 0, 0, nq, nr);
      mqlo = nq; mrlo = nr; mqhi = hq; mrhi = hr;
    end
    exp4_q.push_back(mq4);   exp4_r.push_back(mr4);
    exp8_q.push_back(mq8);   exp8_r.push_back(mr8);
    explo_q.push_back(mqlo); explo_r.push_back(mrlo);
    exphi_q.push_back(mqhi); exphi_r.push_back(mrhi);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: compare every device output shortly after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp4_q.size() > 0) begin
        chk("q4", int'(q4), exp4_q.pop_front());
        chk("rco4", int'(rco4), exp4_r.pop_front());
      end
      if (exp8_q.size() > 0) begin
        chk("q8", int'(q8), exp8_q.pop_front());
        chk("rco8", int'(rco8), exp8_r.pop_front());
      end
      if (explo_q.size() > 0) begin
        chk("q_lo", int'(q_lo), explo_q.pop_front());
        chk("rco_lo", int'(rco_lo), explo_r.pop_front());
        chk("q_hi", int'(q_hi), exphi_q.pop_front());
        chk("rco_hi", int'(rco_hi), exphi_r.pop_front());
      end
    end
  end

  task automatic set4(input logic e, input logic [2:0] m, input logic [3:0] d,
                      input logic s);
    enb4 = e; m4 = m; d4 = d; s4 = s;
  endtask

  task automatic set8(input logic e, input logic [2:0] m, input logic [7:0] d,
                      input logic s);
    enb8 = e; m8 = m; d8 = d; s8 = s;
  endtask

  initial begin
    rst_n = 1'b0;
    set4(1'b1, MODO_UP, 4'h0, 1'b0);
    set8(1'b0, MODO_SHL, 8'h00, 1'b0);
    enb_c = 1'b0;
    #1;
    chk("reset_q4_async", int'(q4), 0);
    chk("reset_rco4_async", int'(rco4), 0);
    @(negedge clk);

    // Reset held across three edges with UP selected, then three counts.
    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (3) cycle();
    chk("t1_q4_after_3_up", int'(q4), 4'b0011);

    // Load and shift left with serial ones.
    set4(1'b1, MODO_LOAD, 4'b1001, 1'b0); cycle();
    set4(1'b1, MODO_SHL, 4'b0000, 1'b1);  cycle();
    chk("t2_rco4_first_shl", int'(rco4), 1);
    cycle();
    chk("t2_q4_second_shl", int'(q4), 4'b0111);

    // Load then rotate right a full turn.
    set4(1'b1, MODO_LOAD, 4'b0001, 1'b0); cycle();
    set4(1'b1, MODO_ROR, 4'b0000, 1'b0);
    repeat (4) cycle();
    chk("t3_q4_full_ror", int'(q4), 4'b0001);

    // 8-bit counter wrap up and down.
    set8(1'b1, MODO_LOAD, 8'hFE, 1'b0); cycle();
    set8(1'b1, MODO_UP, 8'h00, 1'b0);   cycle(); cycle();
    chk("t4_rco8_wrap_up", int'(rco8), 1);
    set8(1'b1, MODO_DOWN, 8'h00, 1'b0); cycle();
    chk("t4_q8_wrap_down", int'(q8), 8'hFF);
    set8(1'b0, MODO_SHL, 8'h00, 1'b0);

    // Disabled register holds; then reset lands between edges.
    set4(1'b1, MODO_LOAD, 4'b1010, 1'b0); cycle();
    set4(1'b0, MODO_SHL, 4'b0000, 1'b1);
    repeat (5) cycle();
    chk("t5_q4_hold", int'(q4), 4'b1010);
    set4(1'b1, MODO_SHL, 4'b0000, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_q4_async_reset", int'(q4), 0);
    chk("t5_q8_async_reset", int'(q8), 0);
    @(negedge clk);
    cycle();
    rst_n = 1'b1;

    // Cascaded counters: lower wraps on edge 16, upper follows one edge later.
    set4(1'b0, MODO_SHL, 4'h0, 1'b0);
    enb_c = 1'b1;
    repeat (16) cycle();
    chk("t6_rco_lo_on_wrap", int'(rco_lo), 1);
    chk("t6_q_hi_before", int'(q_hi), 0);
    cycle();
    chk("t6_q_hi_after", int'(q_hi), 1);

    // Randomised operation across all instances.
    for (int i = 0; i < 400; i++) begin
      set4(1'($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)),
           4'($urandom), 1'($urandom));
      set8(1'($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)),
           8'($urandom), 1'($urandom));
      enb_c = 1'($urandom_range(0, 3) != 0);
      cycle();
    end

    chk("queues_drained", exp4_q.size() + exp8_q.size() + explo_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
